// File: rtl/tiny_cpu_pkg.sv
// Shared definitions for the tiny single-bus CPU control path.
//   state_e : sequencer states (INIT, FETCH0, FETCH1, DECODE, EXEC0, EXEC1, HALT)
//   OP_*    : 4-bit opcode values carried in IR[DW-1:DW-OPW]
//   ctrl_t  : the twelve BUS/register strobes driven by the sequencer
package tiny_cpu_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_FETCH0,
    ST_FETCH1,
    ST_DECODE,
    ST_EXEC0,
    ST_EXEC1,
    ST_HALT
  } state_e;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_LDB = 4'h2;
  localparam logic [3:0] OP_MAB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef struct packed {
    logic pc_rst;
    logic pc_plus;
    logic pc_load;
    logic pc_oe;
    logic mar_write;
    logic ir_write;
    logic mem_oe;
    logic a_write;
    logic a_out;
    logic b_write;
    logic b_out;
    logic alu_oe;
  } ctrl_t;

endpackage

// File: rtl/tiny_ctrl_decode.sv
// Combinational control-word decoder: (state, latched opcode) -> strobes.
// Ports:
//   state_i : current sequencer state
//   op_i    : opcode latched in DECODE
//   ctrl_o  : strobe bundle for the whole of the current state
module tiny_ctrl_decode
  import tiny_cpu_pkg::*;
#(
  parameter int unsigned OPW = 4
) (
  input  state_e         state_i,
  input  logic [OPW-1:0] op_i,
  output ctrl_t          ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      ST_INIT: ctrl_o.pc_rst = 1'b1;
      ST_FETCH0: begin
        ctrl_o.pc_oe     = 1'b1;
        ctrl_o.mar_write = 1'b1;
      end
      ST_FETCH1: begin
        ctrl_o.mem_oe   = 1'b1;
        ctrl_o.ir_write = 1'b1;
        ctrl_o.pc_plus  = 1'b1;
      end
      ST_EXEC0: begin
        case (op_i)
          OPW'(OP_LDA), OPW'(OP_LDB), OPW'(OP_JMP): begin
            // Operand byte follows the opcode: address it via the PC.
            ctrl_o.pc_oe     = 1'b1;
            ctrl_o.mar_write = 1'b1;
          end
          OPW'(OP_MAB): begin
            ctrl_o.a_out   = 1'b1;
            ctrl_o.b_write = 1'b1;
          end
          OPW'(OP_ADD): begin
            ctrl_o.alu_oe  = 1'b1;
            ctrl_o.a_write = 1'b1;
          end
          default: ctrl_o = '0;
        endcase
      end
      ST_EXEC1: begin
        case (op_i)
          OPW'(OP_LDA): begin
            ctrl_o.mem_oe  = 1'b1;
            ctrl_o.a_write = 1'b1;
            ctrl_o.pc_plus = 1'b1;
          end
          OPW'(OP_LDB): begin
            ctrl_o.mem_oe  = 1'b1;
            ctrl_o.b_write = 1'b1;
            ctrl_o.pc_plus = 1'b1;
          end
          OPW'(OP_JMP): begin
            ctrl_o.mem_oe  = 1'b1;
            ctrl_o.pc_load = 1'b1;
          end
          default: ctrl_o = '0;
        endcase
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/tiny_control_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the 8-bit single-bus CPU.
// Holds the state register, latched opcode and retired-instruction count;
// strobe decode lives in tiny_ctrl_decode.
// Ports:
//   CLK, RST (async, active high), RUN (sampled in FETCH0), IR (IR OUT value)
//   PC_RST/PC_PLUS/PC_LOAD/PC_OE, MAR_WRITE, IR_WRITE, MEM_OE,
//   A_WRITE/A_OUT, B_WRITE/B_OUT, ALU_OE : datapath strobes
//   HALTED : in HALT;  ERR : illegal opcode trapped;  ICNT : retired count
// Build option: TINY_SEQ_ILLEGAL_TRAP_EN traps undefined opcodes into HALT
// with a sticky ERR; without it they execute as NOP and ERR is 0.
module tiny_control_sequencer
  import tiny_cpu_pkg::*;
#(
  parameter int unsigned DW  = 8,
  parameter int unsigned OPW = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          RUN,
  input  logic [DW-1:0] IR,
  output logic          PC_RST,
  output logic          PC_PLUS,
  output logic          PC_LOAD,
  output logic          PC_OE,
  output logic          MAR_WRITE,
  output logic          IR_WRITE,
  output logic          MEM_OE,
  output logic          A_WRITE,
  output logic          A_OUT,
  output logic          B_WRITE,
  output logic          B_OUT,
  output logic          ALU_OE,
  output logic          HALTED,
  output logic          ERR,
  output logic [7:0]    ICNT
);

  state_e         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [7:0]     icnt_q, icnt_d;
  ctrl_t          ctrl, ctrl_out;
  logic           unused_ir_low;

  assign unused_ir_low = ^IR[DW-OPW-1:0];

`ifdef TINY_SEQ_ILLEGAL_TRAP_EN
  logic err_q, err_d;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_INIT;
      op_q    <= '0;
      icnt_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      icnt_q  <= icnt_d;
    end
  end

`ifdef TINY_SEQ_ILLEGAL_TRAP_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) err_q <= 1'b0;
    else     err_q <= err_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    icnt_d  = icnt_q;
`ifdef TINY_SEQ_ILLEGAL_TRAP_EN
    err_d   = err_q;
`endif
    case (state_q)
      ST_INIT:   state_d = ST_FETCH0;
      ST_FETCH0: if (RUN) state_d = ST_FETCH1;
      ST_FETCH1: state_d = ST_DECODE;
      ST_DECODE: begin
        state_d = ST_EXEC0;
        op_d    = IR[DW-1:DW-OPW];
      end
      ST_EXEC0: begin
        // Single-byte instructions retire here; two-byte ones defer to EXEC1.
        state_d = ST_FETCH0;
        icnt_d  = icnt_q + 8'd1;
        case (op_q)
          OPW'(OP_LDA), OPW'(OP_LDB), OPW'(OP_JMP): begin
            state_d = ST_EXEC1;
            icnt_d  = icnt_q;
          end
          OPW'(OP_HLT): state_d = ST_HALT;
          OPW'(OP_NOP), OPW'(OP_MAB), OPW'(OP_ADD): state_d = ST_FETCH0;
          default: begin
`ifdef TINY_SEQ_ILLEGAL_TRAP_EN
            state_d = ST_HALT;
            icnt_d  = icnt_q;
            err_d   = 1'b1;
`else
            state_d = ST_FETCH0;
`endif
          end
        endcase
      end
      ST_EXEC1: begin
        state_d = ST_FETCH0;
        icnt_d  = icnt_q + 8'd1;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_INIT;
    endcase
  end

  tiny_ctrl_decode #(.OPW(OPW)) u_decode (
    .state_i (state_q),
    .op_i    (op_q),
    .ctrl_o  (ctrl)
  );

  // The reset state is INIT, whose decode is PC_RST; strobes are held low
  // while RST is high so PC_RST only appears in the cycle after release.
  assign ctrl_out  = RST ? '0 : ctrl;

  assign PC_RST    = ctrl_out.pc_rst;
  assign PC_PLUS   = ctrl_out.pc_plus;
  assign PC_LOAD   = ctrl_out.pc_load;
  assign PC_OE     = ctrl_out.pc_oe;
  assign MAR_WRITE = ctrl_out.mar_write;
  assign IR_WRITE  = ctrl_out.ir_write;
  assign MEM_OE    = ctrl_out.mem_oe;
  assign A_WRITE   = ctrl_out.a_write;
  assign A_OUT     = ctrl_out.a_out;
  assign B_WRITE   = ctrl_out.b_write;
  assign B_OUT     = ctrl_out.b_out;
  assign ALU_OE    = ctrl_out.alu_oe;
  assign HALTED    = (state_q == ST_HALT);
  assign ICNT      = icnt_q;
`ifdef TINY_SEQ_ILLEGAL_TRAP_EN
  assign ERR       = err_q;
`else
  assign ERR       = 1'b0;
`endif

  a_pc_onehot: assert property (@(posedge CLK) disable iff (RST)
    $onehot0({PC_RST, PC_PLUS, PC_LOAD}));
  a_bus_single_driver: assert property (@(posedge CLK) disable iff (RST)
    $onehot0({PC_OE, MEM_OE, A_OUT, B_OUT, ALU_OE}));

endmodule

// File: tb/tb_tiny_control_sequencer.sv
module tb_tiny_control_sequencer;

  logic       CLK = 1'b0;
  logic       RST, RUN;
  logic [7:0] IR;
  logic PC_RST, PC_PLUS, PC_LOAD, PC_OE, MAR_WRITE, IR_WRITE, MEM_OE;
  logic A_WRITE, A_OUT, B_WRITE, B_OUT, ALU_OE, HALTED, ERR;
  logic [7:0] ICNT;
  logic [11:0] obs;

  int checks = 0;
  int failures = 0;
  int unsigned icnt_m = 0;

  localparam logic [11:0] W_PCRST = 12'h800, W_PLUS = 12'h400, W_LOAD = 12'h200,
                          W_PCOE  = 12'h100, W_MARW = 12'h080, W_IRW  = 12'h040,
                          W_MEMOE = 12'h020, W_AW   = 12'h010, W_AOUT = 12'h008,
                          W_BW    = 12'h004, W_BOUT = 12'h002, W_ALU  = 12'h001;

  localparam int K_LDA = 0, K_MIX = 1, K_NOP = 2, K_UNDEF = 3;

  tiny_control_sequencer #(.DW(8), .OPW(4)) dut (
    .CLK(CLK), .RST(RST), .RUN(RUN), .IR(IR),
    .PC_RST(PC_RST), .PC_PLUS(PC_PLUS), .PC_LOAD(PC_LOAD), .PC_OE(PC_OE),
    .MAR_WRITE(MAR_WRITE), .IR_WRITE(IR_WRITE), .MEM_OE(MEM_OE),
    .A_WRITE(A_WRITE), .A_OUT(A_OUT), .B_WRITE(B_WRITE), .B_OUT(B_OUT),
    .ALU_OE(ALU_OE), .HALTED(HALTED), .ERR(ERR), .ICNT(ICNT)
  );

  always #5 CLK = ~CLK;

  assign obs = {PC_RST, PC_PLUS, PC_LOAD, PC_OE, MAR_WRITE, IR_WRITE,
                MEM_OE, A_WRITE, A_OUT, B_WRITE, B_OUT, ALU_OE};

  // Expected strobes for cycle c of an instruction (0 = FETCH0 ... 4 = EXEC1).
  function automatic logic [11:0] exp_word(input logic [3:0] op, input int unsigned c);
    logic [11:0] w;
    w = '0;
    case (c)
      0: w = W_PCOE | W_MARW;
      1: w = W_MEMOE | W_IRW | W_PLUS;
      3: case (op)
           4'h1, 4'h2, 4'h5: w = W_PCOE | W_MARW;
           4'h3:             w = W_AOUT | W_BW;
           4'h4:             w = W_ALU | W_AW;
           default:          w = '0;
         endcase
      4: case (op)
           4'h1:    w = W_MEMOE | W_AW | W_PLUS;
           4'h2:    w = W_MEMOE | W_BW | W_PLUS;
           4'h5:    w = W_MEMOE | W_LOAD;
           default: w = '0;
         endcase
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic int unsigned instr_len(input logic [3:0] op);
    return (op == 4'h1 || op == 4'h2 || op == 4'h5) ? 5 : 4;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Leaves the bench in the FETCH0 cycle following INIT.
  task automatic test_reset();
    RST = 1'b1; RUN = 1'b1; IR = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (obs !== 12'h000) begin failures++; $display("FAIL reset_strobes got=%h exp=%h", obs, 12'h000); end
    checks++;
    if (ICNT !== 8'd0) begin failures++; $display("FAIL reset_icnt got=%0d exp=0", ICNT); end
    checks++;
    if (HALTED !== 1'b0 || ERR !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", HALTED, ERR); end
    RST = 1'b0;
    #1;
    checks++;
    if (obs !== W_PCRST) begin failures++; $display("FAIL init_pcrst got=%h exp=%h", obs, W_PCRST); end
    icnt_m = 0;
    tick();
  endtask

  // Runs n instructions from FETCH0, with random RUN stalls in mixed mode.
  task automatic test_program(input int n, input int kind);
    logic [3:0] op;
    int unsigned stall;
    for (int i = 0; i < n; i++) begin
      case (kind)
        K_LDA:   op = 4'h1;
        K_NOP:   op = 4'h0;
        K_UNDEF: op = 4'($urandom_range(6, 14));
        default: begin
`ifdef TINY_SEQ_ILLEGAL_TRAP_EN
          op = 4'($urandom_range(0, 5));
`else
          op = 4'($urandom_range(0, 14));
`endif
        end
      endcase
      stall = (kind == K_MIX) ? $urandom_range(0, 2) : 0;
      for (int s = 0; s < int'(stall); s++) begin
        RUN = 1'b0;
        IR  = 8'($urandom);
        checks++;
        if (obs !== (W_PCOE | W_MARW)) begin failures++; $display("FAIL run_stall_strobes got=%h exp=%h", obs, W_PCOE | W_MARW); end
        checks++;
        if (ICNT !== 8'(icnt_m)) begin failures++; $display("FAIL run_stall_icnt got=%0d exp=%0d", ICNT, icnt_m); end
        tick();
      end
      RUN = 1'b1;
      IR  = {op, 4'($urandom)};
      for (int unsigned c = 0; c < instr_len(op); c++) begin
        checks++;
        if (obs !== exp_word(op, c)) begin
          failures++;
          $display("FAIL prog_strobes op=%h cyc=%0d got=%h exp=%h", op, c, obs, exp_word(op, c));
        end
        checks++;
        if (ICNT !== 8'(icnt_m) || HALTED !== 1'b0 || ERR !== 1'b0) begin
          failures++;
          $display("FAIL prog_status op=%h cyc=%0d got icnt=%0d h=%b e=%b exp icnt=%0d h=0 e=0",
                   op, c, ICNT, HALTED, ERR, icnt_m);
        end
        if (c >= 1) RUN = 1'($urandom_range(0, 1));
        if (c >= 3) IR = 8'($urandom);
        tick();
      end
      icnt_m = (icnt_m + 1) % 256;
      checks++;
      if (ICNT !== 8'(icnt_m)) begin failures++; $display("FAIL prog_retire_icnt got=%0d exp=%0d", ICNT, icnt_m); end
    end
  endtask

  task automatic test_halt();
    logic [3:0] op;
    op  = 4'hF;
    RUN = 1'b1;
    IR  = {op, 4'($urandom)};
    for (int unsigned c = 0; c < 4; c++) begin
      checks++;
      if (obs !== exp_word(op, c)) begin failures++; $display("FAIL hlt_strobes cyc=%0d got=%h exp=%h", c, obs, exp_word(op, c)); end
      tick();
    end
    icnt_m = (icnt_m + 1) % 256;
    for (int k = 0; k < 20; k++) begin
      RUN = 1'($urandom_range(0, 1));
      IR  = 8'($urandom);
      checks++;
      if (HALTED !== 1'b1 || obs !== 12'h000) begin
        failures++;
        $display("FAIL halt_hold k=%0d got h=%b strobes=%h exp h=1 strobes=000", k, HALTED, obs);
      end
      checks++;
      if (ICNT !== 8'(icnt_m)) begin failures++; $display("FAIL halt_icnt got=%0d exp=%0d", ICNT, icnt_m); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    test_reset();
    test_program(3, K_NOP);
    RUN = 1'b1;
    IR  = {4'h2, 4'($urandom)};
    repeat (4) tick();
    checks++;
    if (obs !== (W_MEMOE | W_BW | W_PLUS)) begin failures++; $display("FAIL ldb_exec1 got=%h exp=%h", obs, W_MEMOE | W_BW | W_PLUS); end
    #2 RST = 1'b1;
    #1;
    checks++;
    if (B_WRITE !== 1'b0 || obs !== 12'h000) begin failures++; $display("FAIL async_rst_strobes got=%h exp=000", obs); end
    checks++;
    if (ICNT !== 8'd0) begin failures++; $display("FAIL async_rst_icnt got=%0d exp=0", ICNT); end
    tick();
    RST = 1'b0;
    #1;
    checks++;
    if (obs !== W_PCRST) begin failures++; $display("FAIL rerelease_pcrst got=%h exp=%h", obs, W_PCRST); end
    icnt_m = 0;
    tick();
  endtask

  task automatic test_wrap();
    test_reset();
    test_program(256, K_NOP);
    checks++;
    if (ICNT !== 8'd0) begin failures++; $display("FAIL icnt_wrap got=%0d exp=0", ICNT); end
  endtask

  task automatic test_illegal();
    test_program(3, K_MIX);
`ifdef TINY_SEQ_ILLEGAL_TRAP_EN
    RUN = 1'b1;
    IR  = {4'h9, 4'($urandom)};
    for (int unsigned c = 0; c < 4; c++) begin
      checks++;
      if (obs !== exp_word(4'h9, c) || ERR !== 1'b0) begin
        failures++;
        $display("FAIL illegal_seq cyc=%0d got strobes=%h err=%b exp strobes=%h err=0", c, obs, ERR, exp_word(4'h9, c));
      end
      tick();
    end
    for (int k = 0; k < 6; k++) begin
      RUN = 1'($urandom_range(0, 1));
      checks++;
      if (ERR !== 1'b1 || HALTED !== 1'b1 || obs !== 12'h000 || ICNT !== 8'(icnt_m)) begin
        failures++;
        $display("FAIL illegal_trap got e=%b h=%b strobes=%h icnt=%0d exp e=1 h=1 strobes=000 icnt=%0d",
                 ERR, HALTED, obs, ICNT, icnt_m);
      end
      tick();
    end
    test_reset();
`else
    test_program(6, K_UNDEF);
`endif
  endtask

  initial begin
    RST = 1'b1; RUN = 1'b0; IR = 8'h00;
    test_reset();
    test_program(4, K_LDA);
    test_program(60, K_MIX);
    test_halt();
    test_reset_mid();
    test_wrap();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
